truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner_pkg.sv | 16 +
 rtl/truth_table_scanner_settle_timer.sv | 28 ++
 rtl/truth_table_scanner.sv | 126 ++++++++++++
 tb/tb_truth_table_scanner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth-table scanner.
// Sweep state encoding plus combination, index and mismatch-counter widths.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_COMB = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 5;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle timer: loads a hold count, counts down while enabled, flags expiry at zero.
// Zero-latency expire flag; no flow control, the caller gates it through load/en.
module tt_settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps {x,y,z,w} through all 16 combinations, captures s_i and compares to a golden mask.
// done arrives 16*(SETTLE+1) edges after start; no backpressure, abort cancels a sweep.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_COMB-1:0] expected,
  output logic [IDX_W-1:0]    xyzw_o,
  input  logic                s_i,
  output logic [NUM_COMB-1:0] table_o,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [CNT_W-1:0]    mismatch_count,
  output logic [IDX_W-1:0]    first_fail,
  output logic                fail_valid
);

  localparam int unsigned TW = 4;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    index;
  logic [NUM_COMB-1:0] exp_q;
  logic                settle_expired;
  logic                miss;
  logic                last_comb;
  logic [CNT_W-1:0]    cnt_nxt;

  // Timer reloads outside DRIVE so each DRIVE phase starts with SETTLE-1 left.
  tt_settle_timer #(.W(TW)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state != DRIVE),
    .load_val (TW'(SETTLE - 1)),
    .en       (state == DRIVE),
    .expired  (settle_expired)
  );

  assign miss      = s_i ^ exp_q[index];
  assign last_comb = (index == IDX_W'(NUM_COMB - 1));
  assign cnt_nxt   = mismatch_count + {{(CNT_W-1){1'b0}}, miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    xyzw_o    = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy   = 1'b1;
        xyzw_o = index;
        if (abort)               state_nxt = IDLE;
        else if (settle_expired) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy   = 1'b1;
        xyzw_o = index;
        if (abort)          state_nxt = IDLE;
        else if (last_comb) state_nxt = DONE;
        else                state_nxt = DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index          <= '0;
      exp_q          <= '0;
      table_o        <= '0;
      mismatch_count <= '0;
      first_fail     <= '0;
      fail_valid     <= 1'b0;
      match          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q          <= expected;
            table_o        <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
            fail_valid     <= 1'b0;
            match          <= 1'b0;
            index          <= '0;
          end
        end
        SAMPLE: begin
          // An abort on the sampling edge drops the sample and skips the verdict.
          if (!abort) begin
            table_o[index] <= s_i;
            mismatch_count <= cnt_nxt;
            if (miss && !fail_valid) begin
              first_fail <= index;
              fail_valid <= 1'b1;
            end
            if (last_comb) match <= (cnt_nxt == '0);
            else           index <= index + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: two scanner instances (SETTLE=1 and SETTLE=3) driven by a mask-defined function.
// Checks reset, match/mismatch verdicts, latency, abort, mid-sweep reset and ignored starts.
module tb_truth_table_scanner;

  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_fail;

  logic        start1, abort1, s1, busy1, done1, match1, fv1;
  logic [15:0] exp1, fmask1, table1;
  logic [3:0]  xyzw1, ff1;
  logic [4:0]  cnt1;

  logic        start3, abort3, s3, busy3, done3, match3, fv3;
  logic [15:0] exp3, fmask3, table3;
  logic [3:0]  xyzw3, ff3;
  logic [4:0]  cnt3;

  truth_table_scanner #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1),
    .xyzw_o(xyzw1), .s_i(s1), .table_o(table1), .busy(busy1), .done(done1),
    .match(match1), .mismatch_count(cnt1), .first_fail(ff1), .fail_valid(fv1)
  );

  truth_table_scanner #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .expected(exp3),
    .xyzw_o(xyzw3), .s_i(s3), .table_o(table3), .busy(busy3), .done(done3),
    .match(match3), .mismatch_count(cnt3), .first_fail(ff3), .fail_valid(fv3)
  );

  // Function under test: output is the mask bit selected by the driven combination.
  always_comb s1 = fmask1[xyzw1];
  always_comb s3 = fmask3[xyzw3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_sweep(input int sel, input bit poke, output int lat,
                           output int pulses, output logic m_at_done);
    logic d;
    lat = -1; pulses = 0; m_at_done = 1'b0;
    @(negedge clk);
    if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      start1 = 1'b0; start3 = 1'b0;
      if (poke && n == 10) start1 = 1'b1;
      d = (sel == 3) ? done3 : done1;
      if (d) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          m_at_done = (sel == 3) ? match3 : match1;
          if (poke) start1 = 1'b1;
        end
      end
      if (lat >= 0 && n >= lat + 4) break;
    end
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (table1 !== 16'h0000) begin n_fail++; $display("FAIL rst_table: got %h want 0000", table1); end
    n_checks++; if (xyzw1 !== 4'h0) begin n_fail++; $display("FAIL rst_xyzw: got %h want 0", xyzw1); end
    n_checks++; if ({busy1, done1, match1, fv1} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {busy1, done1, match1, fv1}); end
    n_checks++; if ({cnt1, ff1} !== 9'd0) begin n_fail++; $display("FAIL rst_cnt_ff: got %h want 0", {cnt1, ff1}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_match;
    int lat, pulses; logic m;
    fmask1 = 16'h5516; exp1 = 16'h5516;
    run_sweep(1, 1'b0, lat, pulses, m);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL match_latency: got %0d want 32", lat); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL match_pulses: got %0d want 1", pulses); end
    n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL match_flag: got %b want 1", m); end
    n_checks++; if (table1 !== 16'h5516) begin n_fail++; $display("FAIL match_table: got %h want 5516", table1); end
    n_checks++; if (cnt1 !== 5'd0) begin n_fail++; $display("FAIL match_cnt: got %0d want 0", cnt1); end
    n_checks++; if (fv1 !== 1'b0) begin n_fail++; $display("FAIL match_fv: got %b want 0", fv1); end
  endtask

  task automatic test_single_mismatch;
    int lat, pulses; logic m;
    fmask1 = 16'h5516; exp1 = 16'h5517;
    run_sweep(1, 1'b0, lat, pulses, m);
    n_checks++; if (m !== 1'b0) begin n_fail++; $display("FAIL mm1_match: got %b want 0", m); end
    n_checks++; if (cnt1 !== 5'd1) begin n_fail++; $display("FAIL mm1_cnt: got %0d want 1", cnt1); end
    n_checks++; if (ff1 !== 4'd0) begin n_fail++; $display("FAIL mm1_first: got %0d want 0", ff1); end
    n_checks++; if (fv1 !== 1'b1) begin n_fail++; $display("FAIL mm1_fv: got %b want 1", fv1); end
    n_checks++; if (match1 !== 1'b0) begin n_fail++; $display("FAIL mm1_match_held: got %b want 0", match1); end
  endtask

  task automatic test_all_fail_settle3;
    int lat, pulses; logic m;
    fmask3 = 16'h0000; exp3 = 16'hFFFF;
    run_sweep(3, 1'b0, lat, pulses, m);
    n_checks++; if (lat !== 64) begin n_fail++; $display("FAIL s3_latency: got %0d want 64", lat); end
    n_checks++; if (cnt3 !== 5'd16) begin n_fail++; $display("FAIL s3_cnt: got %0d want 16", cnt3); end
    n_checks++; if (ff3 !== 4'd0) begin n_fail++; $display("FAIL s3_first: got %0d want 0", ff3); end
    n_checks++; if (fv3 !== 1'b1) begin n_fail++; $display("FAIL s3_fv: got %b want 1", fv3); end
    n_checks++; if (table3 !== 16'h0000) begin n_fail++; $display("FAIL s3_table: got %h want 0000", table3); end
    n_checks++; if (m !== 1'b0) begin n_fail++; $display("FAIL s3_match: got %b want 0", m); end
  endtask

  task automatic test_abort;
    int lat, pulses, dcnt; logic m; bit ok;
    fmask1 = 16'h5516; exp1 = 16'h5516;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (xyzw1 == 4'd5) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_reach5: got %b want 1", ok); end
    abort1 = 1'b1;
    @(posedge clk); #1; abort1 = 1'b0;
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy1); end
    n_checks++; if (xyzw1 !== 4'd0) begin n_fail++; $display("FAIL abort_xyzw: got %h want 0", xyzw1); end
    n_checks++; if (table1 !== 16'h0016) begin n_fail++; $display("FAIL abort_partial: got %h want 0016", table1); end
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (done1) dcnt++; end
    n_checks++; if (dcnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", dcnt); end
    run_sweep(1, 1'b0, lat, pulses, m);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL abort_resweep_lat: got %0d want 32", lat); end
    n_checks++; if (table1 !== 16'h5516) begin n_fail++; $display("FAIL abort_resweep_table: got %h want 5516", table1); end
    // Abort landing on the final sample must suppress the verdict.
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (xyzw1 == 4'd15) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    n_checks++; if ((ok && busy1 && xyzw1 == 4'd15) !== 1'b1) begin n_fail++; $display("FAIL abort_last_setup: got busy=%b xyzw=%h want 1/f", busy1, xyzw1); end
    abort1 = 1'b1;
    @(posedge clk); #1; abort1 = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 8; n++) begin if (done1) dcnt++; @(posedge clk); #1; end
    n_checks++; if (dcnt !== 0) begin n_fail++; $display("FAIL abort_last_done: got %0d want 0", dcnt); end
    n_checks++; if (match1 !== 1'b0) begin n_fail++; $display("FAIL abort_last_match: got %b want 0", match1); end
  endtask

  task automatic test_reset_mid;
    int lat, pulses, dcnt; logic m;
    fmask1 = 16'h5516; exp1 = 16'h0000;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    n_checks++; if ((table1 != 16'h0000 && cnt1 != 5'd0) !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got table=%h cnt=%0d want nonzero", table1, cnt1); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (table1 !== 16'h0000) begin n_fail++; $display("FAIL rmid_table: got %h want 0000", table1); end
    n_checks++; if ({busy1, done1, match1, fv1} !== 4'b0000) begin n_fail++; $display("FAIL rmid_flags: got %b want 0000", {busy1, done1, match1, fv1}); end
    n_checks++; if ({cnt1, ff1, xyzw1} !== 13'd0) begin n_fail++; $display("FAIL rmid_cnt_ff_xyzw: got %h want 0", {cnt1, ff1, xyzw1}); end
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (done1 || busy1) dcnt++; end
    n_checks++; if (dcnt !== 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d want 0", dcnt); end
    exp1 = 16'h5516;
    run_sweep(1, 1'b0, lat, pulses, m);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL rmid_resweep_lat: got %0d want 32", lat); end
    n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL rmid_resweep_match: got %b want 1", m); end
  endtask

  task automatic test_back_to_back;
    int lat, pulses; logic m;
    fmask1 = 16'h5516; exp1 = 16'h5516;
    run_sweep(1, 1'b1, lat, pulses, m);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL b2b_latency: got %0d want 32", lat); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_no_restart: got busy=%b want 0", busy1); end
    n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL b2b_match: got %b want 1", m); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n  = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; exp1 = '0; fmask1 = '0;
    start3 = 1'b0; abort3 = 1'b0; exp3 = '0; fmask3 = '0;
    test_reset();
    test_match();
    test_single_mismatch();
    test_all_fail_settle3();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
